aes_inv_cntx: RTL and testbench
===============================

# aes_inv_cntx

AES-128 inverse-cipher controller: the decryption counterpart of the encryption round controller. It sequences the decryption datapath through an optional forward key-expansion phase, then through the inverse rounds 10 down to 0. It sits between the testbench/bus front end and the decryption core, and drives per-round enables and progress/done status. A cached-last-round-key flag lets repeated decryptions under the same key skip key expansion.

## Interface
- No parameters (AES-128 only: 10 rounds).
- clk  input  1  system clock, rising edge.
- rstn  input  1  reset; one clock; asynchronous, active-low.
- start  input  1  request a decryption; sampled only in IDLE.
- new_key  input  1  sampled with start; 1 forces key expansion.
- abort  input  1  synchronous abort; highest priority.
- accept  output  1  core may load new ciphertext/key (IDLE).
- busy  output  1  high in KEXP or DEC.
- kexp  output  1  high in KEXP.
- rndNo  output  4  KEXP: forward key round being generated (1..10); DEC: inverse round (10..0); IDLE: 0.
- selK10  output  1  core uses the cached K10 for AddRoundKey and as the inverse-schedule seed.
- enbKS  output  1  forward key-schedule step.
- enbIKS  output  1  inverse key-schedule step.
- enbISR, enbISB, enbIMC, enbAR  output  1 each  InvShiftRows, InvSubBytes, InvMixColumns, AddRoundKey enables.
- done  output  1  one-cycle completion pulse.
- completed_round  output  10  one-hot progress indicator.

## Operation
- States: IDLE, KEXP, DEC. An internal key_cached flag is held alongside the state.
- **IDLE** (accept=1):
  - On start & ~abort, if new_key=1 or key_cached=0: go to KEXP with rndNo=1.
  - Otherwise: go to DEC with rndNo=10.
- **KEXP**:
  - enbKS=1. The core derives K_rndNo at the clock edge.
  - rndNo increments by 1 each cycle.
  - At rndNo=10: the core latches K10 into its cache. Next state is DEC with rndNo=10, and key_cached is set to 1.
- **DEC**: rndNo decrements by 1 each cycle.
  - rndNo=10: enbAR=1, selK10=1, enbIKS=1; all other enables 0.
  - rndNo=9..1: enbISR, enbISB, enbAR, enbIMC and enbIKS all 1.
  - rndNo=0: enbISR, enbISB and enbAR are 1; enbIMC=0 and enbIKS=0.
  - After rndNo=0: go to IDLE. done is registered high for exactly that first IDLE cycle.
- Key-register contract: enbIKS at round r means the core computes K_(r-1) at the clock edge, so AddRoundKey at round r always uses K_r.
- Enable defaults: all enables are 0 outside the conditions listed above (including enbAR in IDLE and KEXP).
- completed_round:
  - In DEC with rndNo ≤ 9: only bit (9 − rndNo) is set.
  - All other cases: 0.
- abort:
  - Next cycle: IDLE, rndNo=0, no done pulse.
  - Abort in KEXP clears key_cached.
  - Abort in DEC keeps key_cached.
  - Abort in IDLE with start: remains in IDLE.
- start while busy: ignored, with no queuing.
- new_key while busy: ignored.

## Timing
- Reset values:
  - Outputs: accept=1, rndNo=0; busy, kexp, selK10, done, all enables and completed_round are 0.
  - Internal: state IDLE, key_cached=0.
- Reset asserted mid-operation: immediate return to these values; the cache is invalidated.
- All outputs except done decode combinationally from registered state, rndNo and key_cached. done is registered.
- Latency with key expansion (start sampled at edge 0):
  - KEXP occupies cycles 1..10.
  - DEC rndNo=10..0 occupies cycles 11..21.
  - done is high in cycle 22.
- Latency with cached key: DEC occupies cycles 1..11; done is high in cycle 12.
- Back-to-back: start during the done cycle (IDLE) is accepted. The next operation begins the following cycle, with zero bubble beyond the single IDLE cycle.
- rndNo decrement never wraps: the value after rndNo=0 in DEC is IDLE's 0.

## Test plan
- Reset → start=1, new_key=0 (cache invalid):
  - kexp=1 for cycles 1..10 with rndNo 1..10.
  - DEC rndNo 10..0 in cycles 11..21.
  - done=1 only in cycle 22.
  - enbIMC=0 at rndNo 10 and 0; completed_round=10'h200 at rndNo=0.
- Second start, new_key=0 → no KEXP; rndNo=10 with selK10=1 in cycle 1; done in cycle 12; enbKS never asserted.
- start held high continuously:
  - Operations run back-to-back with exactly one IDLE/done cycle between them.
  - start during DEC has no effect on rndNo.
- abort at KEXP rndNo=5 → IDLE next cycle, no done. A following start with new_key=0 still performs KEXP (cache invalidated).
- abort at DEC rndNo=4 → IDLE, no done. A following start with new_key=0 skips KEXP.
- rstn pulsed low at DEC rndNo=7 → outputs hold reset values immediately. A following start performs KEXP.

Source files
------------

// File: rtl/aes_inv_cntx.sv
// AES-128 inverse-cipher round controller.
// Sequences the decryption core through an optional forward key-expansion
// phase (KEXP, rounds 1..10) and then the inverse rounds 10 down to 0 (DEC).
// A cached-K10 flag lets repeated decryptions under one key skip KEXP.
// Every output except done is decoded combinationally from the registered
// state, round counter and cache flag. done is a registered one-cycle pulse.
module aes_inv_cntx (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       new_key,
  input  logic       abort,
  output logic       accept,
  output logic       busy,
  output logic       kexp,
  output logic [3:0] rndNo,
  output logic       selK10,
  output logic       enbKS,
  output logic       enbIKS,
  output logic       enbISR,
  output logic       enbISB,
  output logic       enbIMC,
  output logic       enbAR,
  output logic       done,
  output logic [9:0] completed_round
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_KEXP = 2'd1;
  localparam logic [1:0] ST_DEC  = 2'd2;

  localparam logic [3:0] RND_FIRST = 4'd1;
  localparam logic [3:0] RND_LAST  = 4'd10;

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [3:0] rnd_reg;
  logic [3:0] rnd_next;
  logic       key_cached_reg;
  logic       key_cached_next;
  logic       done_reg;
  logic       done_next;

  logic       in_idle;
  logic       in_kexp;
  logic       in_dec;
  logic       dec_first;
  logic       dec_last;
  logic       dec_middle;

  // Next-state logic: abort dominates, then the per-state sequencing.
  always_comb begin
    state_next      = state_reg;
    rnd_next        = rnd_reg;
    key_cached_next = key_cached_reg;
    done_next       = 1'b0;

    if (abort) begin
      // Aborting mid-expansion leaves a partial key schedule in the core,
      // so the cached K10 can no longer be trusted. An abort during DEC
      // leaves the cache intact.
      state_next = ST_IDLE;
      rnd_next   = 4'd0;
      if (state_reg == ST_KEXP) begin
        key_cached_next = 1'b0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (new_key || !key_cached_reg) begin
              state_next = ST_KEXP;
              rnd_next   = RND_FIRST;
            end else begin
              state_next = ST_DEC;
              rnd_next   = RND_LAST;
            end
          end
        end

        ST_KEXP: begin
          if (rnd_reg == RND_LAST) begin
            // The core latches K10 on this edge; decryption starts with it.
            state_next      = ST_DEC;
            rnd_next        = RND_LAST;
            key_cached_next = 1'b1;
          end else begin
            rnd_next = rnd_reg + 4'd1;
          end
        end

        ST_DEC: begin
          if (rnd_reg == 4'd0) begin
            // Never wrap below zero: the round after 0 is IDLE's 0.
            state_next = ST_IDLE;
            rnd_next   = 4'd0;
            done_next  = 1'b1;
          end else begin
            rnd_next = rnd_reg - 4'd1;
          end
        end

        default: begin
          state_next = ST_IDLE;
          rnd_next   = 4'd0;
        end
      endcase
    end
  end

  // State, round counter, cache flag and done pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      rnd_reg        <= 4'd0;
      key_cached_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rnd_reg        <= rnd_next;
      key_cached_reg <= key_cached_next;
      done_reg       <= done_next;
    end
  end

  assign in_idle    = (state_reg == ST_IDLE);
  assign in_kexp    = (state_reg == ST_KEXP);
  assign in_dec     = (state_reg == ST_DEC);
  assign dec_first  = in_dec && (rnd_reg == RND_LAST);
  assign dec_last   = in_dec && (rnd_reg == 4'd0);
  assign dec_middle = in_dec && (rnd_reg != RND_LAST) && (rnd_reg != 4'd0);

  // Status and per-round datapath enables.
  // Round 10 is a bare AddRoundKey with the cached K10; rounds 9..1 are full
  // inverse rounds; round 0 drops InvMixColumns. enbIKS at round r makes the
  // core produce K_(r-1), so AddRoundKey in round r always sees K_r.
  always_comb begin
    accept = in_idle;
    busy   = in_kexp || in_dec;
    kexp   = in_kexp;
    rndNo  = rnd_reg;
    selK10 = dec_first;
    enbKS  = in_kexp;
    enbIKS = dec_first || dec_middle;
    enbISR = dec_middle || dec_last;
    enbISB = dec_middle || dec_last;
    enbIMC = dec_middle;
    enbAR  = in_dec;
    done   = done_reg;
  end

  // One-hot progress: bit (9 - rndNo) while decrypting rounds 9..0.
  always_comb begin
    completed_round = 10'd0;
    if (in_dec && (rnd_reg <= 4'd9)) begin
      completed_round = 10'd1 << (4'd9 - rnd_reg);
    end
  end

endmodule

// File: tb/tb_aes_inv_cntx.sv
// Directed testbench for the AES-128 inverse-cipher round controller.
module tb_aes_inv_cntx;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       new_key;
  logic       abort;
  logic       accept;
  logic       busy;
  logic       kexp;
  logic [3:0] rndNo;
  logic       selK10;
  logic       enbKS;
  logic       enbIKS;
  logic       enbISR;
  logic       enbISB;
  logic       enbIMC;
  logic       enbAR;
  logic       done;
  logic [9:0] completed_round;

  int total;
  int bad;

  aes_inv_cntx dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .new_key(new_key),
    .abort(abort),
    .accept(accept),
    .busy(busy),
    .kexp(kexp),
    .rndNo(rndNo),
    .selK10(selK10),
    .enbKS(enbKS),
    .enbIKS(enbIKS),
    .enbISR(enbISR),
    .enbISB(enbISB),
    .enbIMC(enbIMC),
    .enbAR(enbAR),
    .done(done),
    .completed_round(completed_round)
  );

  // {accept,busy,kexp,selK10,enbKS,enbIKS,enbISR,enbISB,enbIMC,enbAR,done}
  logic [10:0] flags;
  assign flags = {accept, busy, kexp, selK10, enbKS, enbIKS,
                  enbISR, enbISB, enbIMC, enbAR, done};

  localparam logic [10:0] F_IDLE    = 11'b10000000000;
  localparam logic [10:0] F_DONE    = 11'b10000000001;
  localparam logic [10:0] F_KEXP    = 11'b01101000000;
  localparam logic [10:0] F_DEC10   = 11'b01010100010;
  localparam logic [10:0] F_DECMID  = 11'b01000111110;
  localparam logic [10:0] F_DEC0    = 11'b01000011010;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] exp_dec_flags(input int r);
    if (r == 10) return F_DEC10;
    if (r == 0)  return F_DEC0;
    return F_DECMID;
  endfunction

  function automatic logic [9:0] exp_cr(input int r);
    logic [9:0] v;
    v = 10'd0;
    if (r <= 9) v[9 - r] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; new_key = 1'b0; abort = 1'b0;
    #12;
    total++;
    if (flags !== F_IDLE || rndNo !== 4'd0 || completed_round !== 10'd0) begin
      bad++;
      $display("FAIL reset: flags=%b rnd=%0d cr=%h want flags=%b rnd=0 cr=0",
               flags, rndNo, completed_round, F_IDLE);
    end
    tick();
    rstn = 1'b1;
    tick();
    total++;
    if (flags !== F_IDLE || rndNo !== 4'd0) begin
      bad++;
      $display("FAIL reset_idle: flags=%b rnd=%0d want %b 0", flags, rndNo, F_IDLE);
    end
  endtask

  task automatic test_kexp_full();
    start = 1'b1; new_key = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      total++;
      if (flags !== F_KEXP || rndNo !== 4'(c) || completed_round !== 10'd0) begin
        bad++;
        $display("FAIL kexp_c%0d: flags=%b rnd=%0d cr=%h want %b %0d 0",
                 c, flags, rndNo, completed_round, F_KEXP, c);
      end
      tick();
    end
    for (int c = 11; c <= 21; c++) begin
      total++;
      if (flags !== exp_dec_flags(21 - c) || rndNo !== 4'(21 - c) ||
          completed_round !== exp_cr(21 - c)) begin
        bad++;
        $display("FAIL dec_c%0d: flags=%b rnd=%0d cr=%h want %b %0d %h",
                 c, flags, rndNo, completed_round, exp_dec_flags(21 - c),
                 21 - c, exp_cr(21 - c));
      end
      if (c == 21) begin
        total++;
        if (completed_round !== 10'h200) begin
          bad++;
          $display("FAIL cr_round0: got %h want 200", completed_round);
        end
      end
      tick();
    end
    total++;
    if (flags !== F_DONE || rndNo !== 4'd0) begin
      bad++;
      $display("FAIL kexp_done_c22: flags=%b rnd=%0d want %b 0", flags, rndNo, F_DONE);
    end
    tick();
    total++;
    if (flags !== F_IDLE) begin
      bad++;
      $display("FAIL done_one_cycle: flags=%b want %b", flags, F_IDLE);
    end
  endtask

  task automatic test_cached();
    int ks_seen;
    ks_seen = 0;
    start = 1'b1; new_key = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (enbKS) ks_seen++;
      total++;
      if (flags !== exp_dec_flags(11 - c) || rndNo !== 4'(11 - c)) begin
        bad++;
        $display("FAIL cached_c%0d: flags=%b rnd=%0d want %b %0d",
                 c, flags, rndNo, exp_dec_flags(11 - c), 11 - c);
      end
      tick();
    end
    total++;
    if (flags !== F_DONE || ks_seen != 0) begin
      bad++;
      $display("FAIL cached_done_c12: flags=%b ks_cycles=%0d want %b 0",
               flags, ks_seen, F_DONE);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; new_key = 1'b0;
    tick();
    for (int op = 0; op < 2; op++) begin
      for (int c = 1; c <= 11; c++) begin
        if (c == 5) new_key = 1'b1;   // ignored while busy
        total++;
        if (flags !== exp_dec_flags(11 - c) || rndNo !== 4'(11 - c)) begin
          bad++;
          $display("FAIL b2b_op%0d_c%0d: flags=%b rnd=%0d want %b %0d",
                   op, c, flags, rndNo, exp_dec_flags(11 - c), 11 - c);
        end
        tick();
      end
      new_key = 1'b0;
      total++;
      if (flags !== F_DONE) begin
        bad++;
        $display("FAIL b2b_done_op%0d: flags=%b want %b", op, flags, F_DONE);
      end
      if (op == 1) start = 1'b0;
      tick();
    end
    total++;
    if (flags !== F_IDLE) begin
      bad++;
      $display("FAIL b2b_stop: flags=%b want %b", flags, F_IDLE);
    end
  endtask

  task automatic test_abort_idle();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++;
    if (flags !== F_IDLE || rndNo !== 4'd0) begin
      bad++;
      $display("FAIL abort_idle: flags=%b rnd=%0d want %b 0", flags, rndNo, F_IDLE);
    end
  endtask

  task automatic test_abort_kexp();
    start = 1'b1; new_key = 1'b1;
    tick();
    start = 1'b0; new_key = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    total++;
    if (flags !== F_KEXP || rndNo !== 4'd5) begin
      bad++;
      $display("FAIL abort_kexp_pre: flags=%b rnd=%0d want %b 5", flags, rndNo, F_KEXP);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (flags !== F_IDLE || rndNo !== 4'd0) begin
      bad++;
      $display("FAIL abort_kexp_post: flags=%b rnd=%0d want %b 0", flags, rndNo, F_IDLE);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL abort_kexp_nodone: done=%b want 0", done);
    end
    start = 1'b1; new_key = 1'b0;
    tick();
    start = 1'b0;
    total++;
    if (flags !== F_KEXP || rndNo !== 4'd1) begin
      bad++;
      $display("FAIL abort_kexp_cache_inval: flags=%b rnd=%0d want %b 1",
               flags, rndNo, F_KEXP);
    end
    for (int c = 1; c < 21; c++) tick();
    total++;
    if (flags !== F_DEC0) begin
      bad++;
      $display("FAIL abort_kexp_rerun_end: flags=%b want %b", flags, F_DEC0);
    end
    tick();
    tick();
  endtask

  task automatic test_abort_dec();
    start = 1'b1; new_key = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    total++;
    if (rndNo !== 4'd4 || flags !== F_DECMID || completed_round !== 10'h020) begin
      bad++;
      $display("FAIL abort_dec_pre: rnd=%0d flags=%b cr=%h want 4 %b 020",
               rndNo, flags, completed_round, F_DECMID);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (flags !== F_IDLE || rndNo !== 4'd0) begin
      bad++;
      $display("FAIL abort_dec_post: flags=%b rnd=%0d want %b 0", flags, rndNo, F_IDLE);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (flags !== F_DEC10 || rndNo !== 4'd10) begin
      bad++;
      $display("FAIL abort_dec_cache_kept: flags=%b rnd=%0d want %b 10",
               flags, rndNo, F_DEC10);
    end
  endtask

  task automatic test_reset_mid();
    // Continues the DEC started at the end of test_abort_dec (now rnd 10).
    for (int c = 0; c < 3; c++) tick();
    total++;
    if (rndNo !== 4'd7) begin
      bad++;
      $display("FAIL rst_mid_pre: rnd=%0d want 7", rndNo);
    end
    rstn = 1'b0;
    #1;
    total++;
    if (flags !== F_IDLE || rndNo !== 4'd0 || completed_round !== 10'd0) begin
      bad++;
      $display("FAIL rst_mid_async: flags=%b rnd=%0d cr=%h want %b 0 0",
               flags, rndNo, completed_round, F_IDLE);
    end
    #1;
    rstn = 1'b1;
    tick();
    start = 1'b1; new_key = 1'b0;
    tick();
    start = 1'b0;
    total++;
    if (flags !== F_KEXP || rndNo !== 4'd1) begin
      bad++;
      $display("FAIL rst_mid_cache_inval: flags=%b rnd=%0d want %b 1",
               flags, rndNo, F_KEXP);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_kexp_full();
    test_cached();
    test_back_to_back();
    test_abort_idle();
    test_abort_kexp();
    test_abort_dec();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
